// File: rtl/opll_write_seq.sv
// Serialises queued register writes onto up to three OPLL sound chips.
// Each write is an address-port strobe, an address wait, a data-port strobe and a data wait, counted in cen ticks.
module opll_write_seq #(
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_WAIT  = 12,
   parameter int DATA_WAIT  = 84
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cen,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_chip,
   input  logic [7:0] req_reg,
   input  logic [7:0] req_val,
   input  logic       flush,
   output logic [7:0] opll_din,
   output logic       opll_addr,
   output logic [2:0] opll_cs_n,
   output logic       opll_wr_n,
   output logic       busy,
   output logic       err
);

   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam int MAX_WAIT = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
   localparam int CNT_W    = $clog2(MAX_WAIT + 1);

   localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_WAIT - 1);
   localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_WAIT - 1);
   localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

   typedef struct packed {
      logic [1:0] chip;
      logic [7:0] reg_num;
      logic [7:0] val;
   } req_t;

   typedef enum logic [2:0] {IDLE, ADDR, AWAIT, DATA, DWAIT} state_t;

   req_t             mem [FIFO_DEPTH];
   req_t             head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             empty;
   logic             push;
   logic             pop;

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] wait_cnt;
   logic             cnt_inc;
   logic             err_set;
   logic [1:0]       cur_chip;
   logic [7:0]       cur_val;

   function automatic logic [2:0] chip_select(input logic [1:0] chip);
      case (chip)
         2'd0:    chip_select = 3'b110;
         2'd1:    chip_select = 3'b101;
         2'd2:    chip_select = 3'b011;
         default: chip_select = 3'b111;
      endcase
   endfunction

   assign empty     = (count == '0);
   assign req_ready = (count != FULL_COUNT);
   assign push      = req_valid && req_ready && !flush;
   assign head      = mem[rd_ptr];
   assign busy      = (state != IDLE) || !empty;

   // NOTE: the storage array has no reset; only pointers and count need one, and a reset would stop RAM inference.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {req_chip, req_reg, req_val};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      err_set    = 1'b0;
      cnt_inc    = 1'b0;
      case (state)
         IDLE: begin
            // A flush in the same cycle cancels the pop; the entry is discarded with the rest.
            if (!empty && !flush) begin
               pop = 1'b1;
               if (head.chip == 2'd3) err_set    = 1'b1;
               else                   next_state = ADDR;
            end
         end
         ADDR:  if (cen) next_state = AWAIT;
         AWAIT: begin
            if (cen) begin
               if (wait_cnt == ADDR_LAST) next_state = DATA;
               else                       cnt_inc    = 1'b1;
            end
         end
         DATA:  if (cen) next_state = DWAIT;
         DWAIT: begin
            if (cen) begin
               if (wait_cnt == DATA_LAST) next_state = IDLE;
               else                       cnt_inc    = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Counter only advances below its terminal value and clears on every state change, so it never wraps.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wait_cnt <= '0;
      end else if (cnt_inc) begin
         wait_cnt <= wait_cnt + 1'b1;
      end else if (next_state != state) begin
         wait_cnt <= '0;
      end
   end

   // Bus outputs are registered from the next state; din/addr keep their value through the waits.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         opll_cs_n <= 3'b111;
         opll_wr_n <= 1'b1;
         opll_addr <= 1'b0;
         opll_din  <= 8'h00;
         cur_chip  <= 2'd0;
         cur_val   <= 8'h00;
      end else if (next_state != state) begin
         case (next_state)
            ADDR: begin
               opll_cs_n <= chip_select(head.chip);
               opll_wr_n <= 1'b0;
               opll_addr <= 1'b0;
               opll_din  <= head.reg_num;
               cur_chip  <= head.chip;
               cur_val   <= head.val;
            end
            DATA: begin
               opll_cs_n <= chip_select(cur_chip);
               opll_wr_n <= 1'b0;
               opll_addr <= 1'b1;
               opll_din  <= cur_val;
            end
            default: begin
               opll_cs_n <= 3'b111;
               opll_wr_n <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         err <= 1'b0;
      end else if (err_set) begin
         err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_opll_write_seq.sv
// Bench for opll_write_seq: directed scenarios plus random bursts, checked against a transaction-level model
// (expected write list in FIFO order, chip-select decode, wait lengths counted in cen ticks).
module tb_opll_write_seq;

   localparam int FIFO_DEPTH = 8;
   localparam int ADDR_WAIT  = 12;
   localparam int DATA_WAIT  = 84;

   logic       clk;
   logic       reset_n;
   logic       cen;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_chip;
   logic [7:0] req_reg;
   logic [7:0] req_val;
   logic       flush;
   logic [7:0] opll_din;
   logic       opll_addr;
   logic [2:0] opll_cs_n;
   logic       opll_wr_n;
   logic       busy;
   logic       err;

   opll_write_seq #(
      .FIFO_DEPTH(FIFO_DEPTH),
      .ADDR_WAIT (ADDR_WAIT),
      .DATA_WAIT (DATA_WAIT)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .cen      (cen),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_chip (req_chip),
      .req_reg  (req_reg),
      .req_val  (req_val),
      .flush    (flush),
      .opll_din (opll_din),
      .opll_addr(opll_addr),
      .opll_cs_n(opll_cs_n),
      .opll_wr_n(opll_wr_n),
      .busy     (busy),
      .err      (err)
   );

   typedef struct {
      int         start;
      logic [2:0] cs_n;
      logic       addr;
      logic [7:0] din;
      int         len;
      int         cens;
      logic       last_cen;
      int         gap_cen;
      logic       gap_last_cen;
   } strobe_t;

   typedef struct {
      logic [1:0] chip;
      logic [7:0] regn;
      logic [7:0] val;
   } txn_t;

   strobe_t obs_q[$];
   txn_t    exp_q[$];
   logic    exp_err;

   int   cyc = 0;
   int   cen_mode = 0;
   logic mon_en = 1'b0;
   int   fall_cyc = -1;
   int   fall_gap_cen = -1;
   logic fall_last_cen = 1'b0;
   int   bad_idle = 0;

   int n_checks = 0;
   int n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // cen pattern: 0 = tied high, 1 = one in four, 2 = random about one in three
   initial begin
      cen = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (cen_mode)
            0:       cen = 1'b1;
            1:       cen = (cyc % 4 == 0);
            default: cen = ($urandom_range(0, 2) == 0);
         endcase
      end
   end

   // Bus monitor: turns the pin activity into strobe records and wait lengths measured in cen ticks.
   initial begin
      strobe_t cur_s;
      logic    prev_wr_n;
      logic    prev_busy;
      int      gap_cen;
      logic    last_cen;
      cur_s     = '{0, 3'b111, 1'b0, 8'h00, 0, 0, 1'b0, 0, 1'b0};
      prev_wr_n = 1'b1;
      prev_busy = 1'b0;
      gap_cen   = 0;
      last_cen  = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (prev_busy && !busy) begin
               fall_cyc      = cyc;
               fall_gap_cen  = gap_cen;
               fall_last_cen = last_cen;
            end
            if (!opll_wr_n) begin
               if (prev_wr_n) begin
                  cur_s.start        = cyc;
                  cur_s.cs_n         = opll_cs_n;
                  cur_s.addr         = opll_addr;
                  cur_s.din          = opll_din;
                  cur_s.len          = 0;
                  cur_s.cens         = 0;
                  cur_s.gap_cen      = gap_cen;
                  cur_s.gap_last_cen = last_cen;
               end
               cur_s.len      = cur_s.len + 1;
               cur_s.cens     = cur_s.cens + (cen ? 1 : 0);
               cur_s.last_cen = cen;
               gap_cen        = 0;
            end else begin
               if (!prev_wr_n) obs_q.push_back(cur_s);
               gap_cen  = gap_cen + (cen ? 1 : 0);
               last_cen = cen;
               if (opll_cs_n !== 3'b111) bad_idle++;
            end
            prev_wr_n = opll_wr_n;
            prev_busy = busy;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [2:0] exp_cs(input logic [1:0] c);
      return ~(3'b001 << c);
   endfunction

   task automatic align();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; holds the request until the handshake completes, then records it in the model.
   task automatic push(input logic [1:0] c, input logic [7:0] r, input logic [7:0] v, output int waited);
      logic rdy;
      txn_t t;
      waited    = 0;
      req_valid = 1'b1;
      req_chip  = c;
      req_reg   = r;
      req_val   = v;
      forever begin
         @(negedge clk);
         rdy = req_ready;
         @(posedge clk);
         #1;
         if (rdy) break;
         waited++;
         if (waited > 3000) begin
            check("push_timeout", rdy, 1);
            break;
         end
      end
      req_valid = 1'b0;
      if (rdy) begin
         if (c == 2'd3) begin
            exp_err = 1'b1;
         end else begin
            t.chip = c;
            t.regn = r;
            t.val  = v;
            exp_q.push_back(t);
         end
      end
   endtask

   task automatic push_rand(input logic [1:0] c);
      int w;
      push(c, 8'($urandom), 8'($urandom), w);
   endtask

   task automatic wait_idle(input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         @(negedge clk);
         if (!busy) break;
      end
      if (k == budget) check("idle_timeout", busy, 0);
   endtask

   // Compares every observed strobe pair against the expected write list, in order.
   task automatic drain(input string name);
      txn_t    t;
      strobe_t a;
      strobe_t d;
      int      n;
      n = 0;
      while (exp_q.size() > 0) begin
         t = exp_q.pop_front();
         if (obs_q.size() < 2) begin
            check($sformatf("%s_missing_strobe_%0d", name, n), obs_q.size(), 2);
            exp_q.delete();
            break;
         end
         a = obs_q.pop_front();
         d = obs_q.pop_front();
         check($sformatf("%s_a%0d_cs_n", name, n), a.cs_n, exp_cs(t.chip));
         check($sformatf("%s_a%0d_port", name, n), a.addr, 0);
         check($sformatf("%s_a%0d_din", name, n), a.din, t.regn);
         check($sformatf("%s_a%0d_cen_in_strobe", name, n), a.cens, 1);
         check($sformatf("%s_a%0d_ends_on_cen", name, n), a.last_cen, 1);
         check($sformatf("%s_await_ticks_%0d", name, n), d.gap_cen, ADDR_WAIT);
         check($sformatf("%s_await_ends_on_cen_%0d", name, n), d.gap_last_cen, 1);
         check($sformatf("%s_d%0d_cs_n", name, n), d.cs_n, exp_cs(t.chip));
         check($sformatf("%s_d%0d_port", name, n), d.addr, 1);
         check($sformatf("%s_d%0d_din", name, n), d.din, t.val);
         check($sformatf("%s_d%0d_cen_in_strobe", name, n), d.cens, 1);
         check($sformatf("%s_d%0d_ends_on_cen", name, n), d.last_cen, 1);
         n++;
      end
      check($sformatf("%s_extra_strobes", name), obs_q.size(), 0);
      obs_q.delete();
   endtask

   initial begin
      int t0;
      int w;
      int n;
      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_chip  = 2'd0;
      req_reg   = 8'h00;
      req_val   = 8'h00;
      flush     = 1'b0;
      exp_err   = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      check("rst_cs_n", opll_cs_n, 3'b111);
      check("rst_wr_n", opll_wr_n, 1);
      check("rst_addr", opll_addr, 0);
      check("rst_din", opll_din, 8'h00);
      check("rst_busy", busy, 0);
      check("rst_ready", req_ready, 1);
      check("rst_err", err, 0);
      mon_en = 1'b1;

      // Single write with cen tied high: exact cycle positions
      cen_mode = 0;
      align();
      t0 = cyc;
      push(2'd0, 8'h10, 8'h55, w);
      wait_idle(400);
      if (obs_q.size() >= 2) begin
         check("s1_addr_strobe_cycle", obs_q[0].start, t0 + 2);
         check("s1_data_strobe_cycle", obs_q[1].start, t0 + 15);
      end else begin
         check("s1_strobe_count", obs_q.size(), 2);
      end
      check("s1_busy_fall_cycle", fall_cyc, t0 + 100);
      check("s1_dwait_ticks", fall_gap_cen, DATA_WAIT);
      drain("s1");

      // cen one in four: strobes stretch to a cen edge, waits count cen ticks
      cen_mode = 1;
      align();
      push_rand(2'd1);
      wait_idle(2000);
      check("s2_dwait_ticks", fall_gap_cen, DATA_WAIT);
      check("s2_dwait_ends_on_cen", fall_last_cen, 1);
      drain("s2");

      // Fill the FIFO behind an in-flight write, then one more that has to stall
      cen_mode = 0;
      align();
      for (int i = 0; i < 9; i++) push_rand(2'($urandom_range(0, 2)));
      @(negedge clk);
      check("s3_ready_when_full", req_ready, 0);
      check("s3_busy_when_full", busy, 1);
      align();
      push(2'd2, 8'($urandom), 8'($urandom), w);
      check("s3_tenth_stalled", (w > 0), 1);
      wait_idle(2500);
      drain("s3");

      // Invalid chip is skipped with err set; the following write goes to chip 2
      check("s4_err_before", err, exp_err);
      align();
      push_rand(2'd3);
      push_rand(2'd2);
      wait_idle(600);
      check("s4_err_after", err, 1);
      check("s4_err_model", err, exp_err);
      drain("s4");

      // flush while A waits after its address strobe; B and C must vanish
      align();
      push_rand(2'd0);
      push_rand(2'd1);
      push_rand(2'd2);
      repeat (3) align();
      flush = 1'b1;
      align();
      flush = 1'b0;
      while (exp_q.size() > 1) void'(exp_q.pop_back());
      @(negedge clk);
      check("s5_busy_in_flight", busy, 1);
      check("s5_ready_after_flush", req_ready, 1);
      wait_idle(600);
      check("s5_dwait_ticks", fall_gap_cen, DATA_WAIT);
      drain("s5");

      // Reset during the data strobe
      align();
      push_rand(2'd1);
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (!opll_wr_n && opll_addr) break;
      end
      check("s6_data_strobe_seen", {opll_wr_n, opll_addr}, 2'b01);
      #1 reset_n = 1'b0;
      align();
      reset_n = 1'b1;
      exp_err = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("s6_cs_n", opll_cs_n, 3'b111);
      check("s6_wr_n", opll_wr_n, 1);
      check("s6_din", opll_din, 8'h00);
      check("s6_addr", opll_addr, 0);
      check("s6_busy", busy, 0);
      check("s6_ready", req_ready, 1);
      check("s6_err", err, exp_err);
      @(negedge clk);
      obs_q.delete();

      // Random bursts with random cen
      cen_mode = 2;
      for (int b = 0; b < 6; b++) begin
         align();
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) push_rand(2'($urandom_range(0, 3)));
         wait_idle(6000);
         check($sformatf("r%0d_err", b), err, exp_err);
         check($sformatf("r%0d_ready", b), req_ready, 1);
         drain($sformatf("r%0d", b));
      end

      check("cs_n_idle_between_strobes", bad_idle, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
